// File: rtl/wr_pps_supervisor.sv
// WR core PPS supervisor: resets the core, validates PPS period, declares lock,
// and restarts the core on timeout or on request.
module wr_pps_supervisor #(
  parameter int unsigned CLK_HZ       = 62500000,
  parameter int unsigned TOL          = 16,
  parameter int unsigned RESET_CYCLES = 1024,
  parameter int unsigned LOCK_COUNT   = 4,
  parameter int unsigned TIMEOUT_S    = 60
) (
  input  logic        clk_sys_i,
  input  logic        rst_n_i,
  input  logic        enable_i,
  input  logic        force_reset_i,
  input  logic        pps_i,
  output logic        wr_reset_o,
  output logic        locked_o,
  output logic [2:0]  state_o,
  output logic [31:0] period_o,
  output logic [15:0] err_count_o,
  output logic [15:0] resync_count_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RESET   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_ACQUIRE = 3'd3,
    ST_LOCKED  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  rst_sync_q;
  logic        run;
  logic        pps_q;
  logic [31:0] cnt_q;
  logic [31:0] good_q, good_d;
  logic [31:0] rst_cnt_q;
  logic [31:0] presc_q, sec_q;
  logic [31:0] period_d;
  logic [31:0] meas;
  logic        pps_edge, meas_good, sec_tick, timeout, count_en;
  logic        err_inc, resync_inc;

  // Assertion is asynchronous; release reaches the logic two clocks later.
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign run = rst_sync_q[1];

  assign pps_edge  = pps_i & ~pps_q;
  assign meas      = cnt_q + 32'd1;
  assign meas_good = (meas >= CLK_HZ - TOL) && (meas <= CLK_HZ + TOL);
  assign sec_tick  = (presc_q == CLK_HZ - 1);
  assign timeout   = ((state_q == ST_WAIT) || (state_q == ST_ACQUIRE)) &&
                     sec_tick && (sec_q == TIMEOUT_S - 1);

  always_comb begin
    state_d    = state_q;
    good_d     = good_q;
    period_d   = period_o;
    err_inc    = 1'b0;
    resync_inc = 1'b0;
    if (!enable_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  state_d = ST_RESET;
        ST_RESET: if (rst_cnt_q == RESET_CYCLES - 1) state_d = ST_WAIT;
        ST_WAIT, ST_ACQUIRE, ST_LOCKED: begin
          if (force_reset_i || timeout) begin
            state_d    = ST_RESET;
            resync_inc = 1'b1;
          end else if (pps_edge) begin
            if (state_q == ST_WAIT) begin
              state_d = ST_ACQUIRE;
              good_d  = '0;
            end else begin
              period_d = meas;
              if (!meas_good) begin
                err_inc = 1'b1;
                good_d  = '0;
                state_d = ST_ACQUIRE;
              end else if (state_q == ST_ACQUIRE) begin
                good_d = good_q + 32'd1;
                if (good_q + 32'd1 == LOCK_COUNT) state_d = ST_LOCKED;
              end
            end
          end else if ((state_q != ST_WAIT) && (cnt_q >= CLK_HZ + TOL)) begin
            err_inc = 1'b1;
            state_d = ST_WAIT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Seconds count only while staying in WAIT/ACQUIRE; any other transition clears it.
  assign count_en = ((state_q == ST_WAIT) || (state_q == ST_ACQUIRE)) &&
                    ((state_d == ST_WAIT) || (state_d == ST_ACQUIRE));

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q        <= ST_IDLE;
      pps_q          <= 1'b0;
      cnt_q          <= '0;
      good_q         <= '0;
      rst_cnt_q      <= '0;
      presc_q        <= '0;
      sec_q          <= '0;
      wr_reset_o     <= 1'b1;
      locked_o       <= 1'b0;
      period_o       <= '0;
      err_count_o    <= '0;
      resync_count_o <= '0;
    end else if (run) begin
      state_q <= state_d;
      pps_q   <= pps_i;
      good_q  <= good_d;
      period_o <= period_d;
      if (pps_edge)         cnt_q <= '0;
      else if (cnt_q != '1) cnt_q <= cnt_q + 32'd1;
      rst_cnt_q <= (state_q == ST_RESET) ? rst_cnt_q + 32'd1 : '0;
      if (count_en) begin
        if (sec_tick) begin
          presc_q <= '0;
          sec_q   <= sec_q + 32'd1;
        end else begin
          presc_q <= presc_q + 32'd1;
        end
      end else begin
        presc_q <= '0;
        sec_q   <= '0;
      end
      if (err_inc && (err_count_o != '1))       err_count_o    <= err_count_o + 16'd1;
      if (resync_inc && (resync_count_o != '1)) resync_count_o <= resync_count_o + 16'd1;
      wr_reset_o <= (state_d == ST_IDLE) || (state_d == ST_RESET);
      locked_o   <= (state_d == ST_LOCKED);
    end
  end

  assign state_o = state_q;

endmodule
